// File: rtl/r2sdf_stage_ctrl.sv
// Control sequencer for one radix-2 single-path delay-feedback FFT stage.
// Counts accepted samples per frame, decodes delay-line/butterfly/twiddle controls, self-drains after the last frame.
module r2sdf_stage_ctrl #(
   parameter int unsigned DELAY_DEPTH   = 4,
   parameter int unsigned CNT_WIDTH     = 3,
   parameter int unsigned TW_ADDR_WIDTH = 8,
   parameter int unsigned TW_STRIDE     = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     di_en,
   input  logic                     di_last,
   output logic                     di_rdy,
   output logic                     buf_shift,
   output logic                     bf_sel,
   output logic                     do_en,
   output logic                     tw_en,
   output logic [TW_ADDR_WIDTH-1:0] tw_addr,
   output logic                     busy,
   output logic                     frame_err
);

   localparam logic [CNT_WIDTH-1:0] CNT_HALF = CNT_WIDTH'(DELAY_DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(2 * DELAY_DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_BFLY    = 3'd2,
      S_LOADOUT = 3'd3,
      S_DRAIN   = 3'd4
   } state_t;

   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
   logic                 err_nxt;
   logic                 acc;

   // State, sample counter and sticky framing error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         frame_err <= err_nxt;
      end
   end

   // Zero-cycle control decode and next-state logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      err_nxt   = frame_err;

      di_rdy    = (state != S_DRAIN);
      acc       = di_en & di_rdy;
      buf_shift = acc | (state == S_DRAIN);
      bf_sel    = (state == S_BFLY);
      do_en     = buf_shift & ((state == S_BFLY) | (state == S_LOADOUT) | (state == S_DRAIN));
      tw_en     = buf_shift & ((state == S_LOADOUT) | (state == S_DRAIN));
      tw_addr   = tw_en ? TW_ADDR_WIDTH'(32'(cnt[CNT_WIDTH-2:0]) * TW_STRIDE) : '0;
      busy      = (state != S_IDLE);

      if (buf_shift) cnt_nxt = cnt + CNT_WIDTH'(1);
      if (acc && di_last && (cnt != CNT_LAST)) err_nxt = 1'b1;

      case (state)
         S_IDLE, S_LOAD: begin
            if (acc) state_nxt = (cnt == CNT_HALF) ? S_BFLY : S_LOAD;
         end
         S_LOADOUT: begin
            if (acc && (cnt == CNT_HALF)) state_nxt = S_BFLY;
         end
         S_BFLY: begin
            if (acc && (cnt == CNT_LAST)) state_nxt = di_last ? S_DRAIN : S_LOADOUT;
         end
         S_DRAIN: begin
            // Drain is exactly M cycles; the counter restarts for the next frame
            if (cnt == CNT_HALF) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: doc/r2sdf_stage_ctrl.md
# r2sdf_stage_ctrl

Sequencer for one radix-2 single-path delay-feedback (R2SDF) FFT stage. It counts accepted samples within a frame and drives the stage's delay line, butterfly, and twiddle ROM. Controls: delay-line shift enable, butterfly/bypass select, twiddle address and enable, output valid. It also drains the delay line after the last frame so the stored differences are emitted without further input. One instance sits beside each stage's delay line and butterfly.

## Interface
- DELAY_DEPTH, 4: stage delay length M; power of two, ≥2.
- CNT_WIDTH, 3: log2(2·M); must equal $clog2(2*DELAY_DEPTH).
- TW_ADDR_WIDTH, 8: twiddle ROM address width.
- TW_STRIDE, 1: twiddle address step per sample (N/(2M) for this stage).

Ports:
- clk  in  1  master clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- di_en  in  1  input sample valid.
- di_last  in  1  qualifies the accepted sample as the frame's last.
- di_rdy  out  1  controller accepts a sample this cycle.
- buf_shift  out  1  delay-line shift enable.
- bf_sel  out  1  1 = butterfly mode (sum out, difference into the delay line); 0 = bypass (input into the delay line).
- do_en  out  1  stage output valid this cycle.
- tw_en  out  1  twiddle multiply applies to this output.
- tw_addr  out  TW_ADDR_WIDTH  twiddle ROM address.
- busy  out  1  state ≠ IDLE.
- frame_err  out  1  sticky misplaced-di_last flag.

## Operation
- Internal registers: state, cnt[CNT_WIDTH-1:0], frame_err. acc = di_en & di_rdy.
- States:
  - IDLE: delay line holds nothing valid.
  - LOAD: first half, nothing pending.
  - BFLY: second half.
  - LOADOUT: first half while emitting the previous frame's differences.
  - DRAIN: self-timed flush.
- Transitions (cnt increments on every buf_shift, wraps mod 2M):
  - IDLE/LOAD on acc: cnt==M-1 → BFLY, else → LOAD.
  - LOADOUT on acc: cnt==M-1 → BFLY, else stay.
  - BFLY on acc at cnt==2M-1: di_last → DRAIN, else → LOADOUT. Otherwise stay.
  - DRAIN every cycle: cnt==M-1 → IDLE with cnt 0.
- No acc → state and cnt hold; gaps of any length are legal.
- di_last accepted when cnt≠2M-1 sets frame_err; the framing is otherwise unaffected. frame_err clears only on reset.
- Decode (combinational from state, cnt, acc):
  - di_rdy = state≠DRAIN.
  - buf_shift = acc | DRAIN.
  - bf_sel = BFLY.
  - do_en = buf_shift & (BFLY | LOADOUT | DRAIN).
  - tw_en = buf_shift & (LOADOUT | DRAIN).
  - tw_addr = tw_en ? (cnt[CNT_WIDTH-2:0]·TW_STRIDE) mod 2^TW_ADDR_WIDTH : 0.
- di_en during DRAIN is not accepted; the upstream stage holds the sample.

## Timing
- Zero-cycle control: all decoded outputs refer to the sample presented in the same cycle. The datapath registers them alongside the data.
- Reset (async assert, sync release) gives: state IDLE, cnt 0, frame_err 0, di_rdy 1, buf_shift 0, bf_sel 0, do_en 0, tw_en 0, tw_addr 0, busy 0.
- Reset mid-frame or mid-DRAIN discards delay-line contents; no further do_en until a new frame reaches BFLY.
- Per frame of 2M accepted samples: the first M have do_en=0 (first frame) or do_en=tw_en=1 (following frames); the last M have do_en=1, bf_sel=1.
- DRAIN lasts exactly M cycles with do_en=tw_en=1 and tw_addr stepping 0..(M-1)·TW_STRIDE. The first cycle after DRAIN is IDLE with di_rdy=1.
- A frame may start in the cycle immediately after DRAIN ends.

## Test plan
- Reset: assert rst_n=0 mid-BFLY at M=4 → all outputs immediately at reset values; after release, di_rdy=1, busy=0.
- Single frame, M=4, di_en continuous 8 cycles, di_last on the 8th → buf_shift cycles 1-12, bf_sel/do_en cycles 5-8, DRAIN cycles 9-12 with di_rdy=0, tw_en=1, tw_addr 0,1,2,3. IDLE at cycle 13.
- Two back-to-back frames, M=4, TW_STRIDE=2 → second frame's samples 1-4 give do_en=tw_en=1, tw_addr 0,2,4,6. Total do_en count 12 over the frames plus 4 in DRAIN.
- Gapped input: di_en toggled 1,0,0,1,… across a frame → cnt and state hold during gaps, buf_shift=0 in gaps, final sequence identical to continuous.
- di_last asserted on accepted sample 3 (cnt=2) → frame_err=1 next cycle and stays 1; the frame completes normally at sample 8.
- di_en held high through DRAIN → no acc during DRAIN; the held sample is accepted in the first IDLE cycle with cnt 0→1, state LOAD.
